// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: data width, reset/bubble defaults and the
// fetch-stage state encoding.
package pipe_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } if_state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush inserts a bubble (NOP, valid=0) while keeping
// pc/pc4; hold freezes every field.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] inst_in,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic [XLEN-1:0] inst,
    output logic            valid
);
    logic [XLEN-1:0] pc_d, pc_q, pc4_d, pc4_q, inst_d, inst_q;
    logic            valid_d, valid_q;

    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (flush) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (!hold) begin
            pc_d    = pc_in;
            pc4_d   = pc_in + 32'd4;
            inst_d  = inst_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            pc4_q   <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc    = pc_q;
    assign pc4   = pc4_q;
    assign inst  = inst_q;
    assign valid = valid_q;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, redirect/stall handling, IF/ID
// capture, sticky misalignment flag and valid-fetch counter.
//   state | meaning
//   RUN   | sequential fetch, IF/ID loads the instruction at pc
//   FLUSH | cycle after a redirect; IF/ID holds a bubble until the target is fetched
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic [XLEN-1:0] pc_seq,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4,
    output logic [XLEN-1:0] if_id_inst,
    output logic            if_id_valid,
    output logic            misalign_err,
    output logic [XLEN-1:0] fetch_cnt
);
    logic [XLEN-1:0] pc_d, pc_q, fetch_cnt_d, fetch_cnt_q;
    logic            misalign_d, misalign_q;
    if_state_t       state_d, state_q;
    logic            ifid_hold, ifid_flush;

    always_comb begin
        pc_d        = pc_q;
        fetch_cnt_d = fetch_cnt_q;
        misalign_d  = misalign_q;
        state_d     = state_q;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        // Redirect beats stall: the wrong-path instruction must never survive a hold.
        if (redirect) begin
            pc_d       = {redirect_target[XLEN-1:2], 2'b00};
            ifid_flush = 1'b1;
            state_d    = FLUSH;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (stall) begin
            ifid_hold = 1'b1;
        end else begin
            pc_d        = pc_seq;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
            state_d     = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            fetch_cnt_q <= '0;
            misalign_q  <= 1'b0;
            state_q     <= RUN;
        end else begin
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
            misalign_q  <= misalign_d;
            state_q     <= state_d;
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .hold    (ifid_hold),
        .flush   (ifid_flush),
        .pc_in   (pc_q),
        .inst_in (imem_rdata),
        .pc      (if_id_pc),
        .pc4     (if_id_pc4),
        .inst    (if_id_inst),
        .valid   (if_id_valid)
    );

    assign imem_addr    = pc_q;
    assign misalign_err = misalign_q;
    assign fetch_cnt    = fetch_cnt_q;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: the driver pushes the expected post-edge state
// into a queue, a monitor pops and compares it after each rising edge.
module tb_if_stage;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifpc4;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] cnt;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_target, pc_seq, imem_addr, imem_rdata;
    logic [31:0] if_id_pc, if_id_pc4, if_id_inst, fetch_cnt;
    logic        if_id_valid, misalign_err;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    always #5 clk = ~clk;

    assign imem_rdata = mem_word(imem_addr);
    assign pc_seq     = imem_addr + 32'd4;

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc_seq          (pc_seq),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .if_id_pc        (if_id_pc),
        .if_id_pc4       (if_id_pc4),
        .if_id_inst      (if_id_inst),
        .if_id_valid     (if_id_valid),
        .misalign_err    (misalign_err),
        .fetch_cnt       (fetch_cnt)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_addr", imem_addr, e.pc);
            chk("if_id_pc", if_id_pc, e.ifpc);
            chk("if_id_pc4", if_id_pc4, e.ifpc4);
            chk("if_id_inst", if_id_inst, e.inst);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("fetch_cnt", fetch_cnt, e.cnt);
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
        end
    end

    // One cycle: drive inputs at negedge, push what the next rising edge must produce.
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] tgt,
                        input logic [31:0] e_pc, input logic [31:0] e_ifpc, input logic e_valid,
                        input logic [31:0] e_cnt, input logic e_mis);
        exp_t e;
        @(negedge clk);
        rst             = r;
        stall           = s;
        redirect        = rd;
        redirect_target = tgt;
        e.pc    = e_pc;
        e.ifpc  = e_ifpc;
        e.ifpc4 = (e_ifpc == 32'd0) ? 32'd0 : e_ifpc + 32'd4;
        e.inst  = e_valid ? mem_word(e_ifpc) : NOP;
        e.valid = e_valid;
        e.cnt   = e_cnt;
        e.mis   = e_mis;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        //    rst  stl  rd   target         pc             ifpc           v     cnt            mis
        step(1'b1, 1'b0, 1'b0, 32'h0,        32'h3000, 32'h0,    1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0,        32'h3000, 32'h0,    1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h3004, 32'h3000, 1'b1, 32'd1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h3008, 32'h3004, 1'b1, 32'd2, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 32'h0,    32'h3008, 32'h3004, 1'b1, 32'd2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h300C, 32'h3008, 1'b1, 32'd3, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h3010, 32'h300C, 1'b1, 32'd4, 1'b0);
        // redirect together with stall: redirect wins
        step(1'b0, 1'b1, 1'b1, 32'h3040,     32'h3040, 32'h300C, 1'b0, 32'd4, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h3044, 32'h3040, 1'b1, 32'd5, 1'b0);
        // stall while in FLUSH keeps the bubble
        step(1'b0, 1'b0, 1'b1, 32'h3060,     32'h3060, 32'h3040, 1'b0, 32'd5, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0,        32'h3060, 32'h3040, 1'b0, 32'd5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h3064, 32'h3060, 1'b1, 32'd6, 1'b0);
        // misaligned target
        step(1'b0, 1'b0, 1'b1, 32'h3046,     32'h3044, 32'h3060, 1'b0, 32'd6, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h3048, 32'h3044, 1'b1, 32'd7, 1'b1);
        // back-to-back redirects, sticky flag survives aligned redirects
        step(1'b0, 1'b0, 1'b1, 32'h3040,     32'h3040, 32'h3044, 1'b0, 32'd7, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h3080,     32'h3080, 32'h3044, 1'b0, 32'd7, 1'b1);
        @(posedge clk);
        #2;
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt_q;
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h3084, 32'h3080, 1'b1, 32'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h3088, 32'h3084, 1'b1, 32'd1, 1'b1);
        // reset mid-stall and mid-redirect discards everything
        step(1'b1, 1'b1, 1'b1, 32'h3047,     32'h3000, 32'h0,    1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h3004, 32'h3000, 1'b1, 32'd1, 1'b0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
